// File: rtl/operands_select.sv
// Decode/execute operand mux with MW-stage bypass, producing ALU inputs A and B.
// Optional macro OPERANDS_OUTREG_EN registers A/B (1 cycle latency, async reset to 0).
module operands_select #(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        opcode,
  input  logic [RWIDTH-1:0] rs1,
  input  logic [RWIDTH-1:0] rs2,
  input  logic [DWIDTH-1:0] pc,
  input  logic [DWIDTH-1:0] rs1d,
  input  logic [DWIDTH-1:0] rs2d,
  input  logic [DWIDTH-1:0] imm,
  input  logic [RWIDTH-1:0] rd_mw,
  input  logic              rwe_mw,
  input  logic [DWIDTH-1:0] wb_data_mw,
  output logic [DWIDTH-1:0] A,
  output logic [DWIDTH-1:0] B
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  logic              fwd1;
  logic              fwd2;
  logic [DWIDTH-1:0] r1;
  logic [DWIDTH-1:0] r2;
  logic [DWIDTH-1:0] a_d;
  logic [DWIDTH-1:0] b_d;

  // x0 is hardwired to zero, so a pending write to it must never be bypassed.
  always_comb begin
    fwd1 = rwe_mw && (rd_mw != '0) && (rd_mw == rs1);
    fwd2 = rwe_mw && (rd_mw != '0) && (rd_mw == rs2);
    r1   = fwd1 ? wb_data_mw : rs1d;
    r2   = fwd2 ? wb_data_mw : rs2d;
  end

  always_comb begin
    a_d = '0;
    b_d = '0;
    case (opcode)
      OP_R: begin
        a_d = r1;
        b_d = r2;
      end
      OP_I_ALU, OP_LOAD, OP_STORE, OP_JALR, OP_CSR: begin
        a_d = r1;
        b_d = imm;
      end
      OP_BRANCH, OP_JAL, OP_AUIPC: begin
        a_d = pc;
        b_d = imm;
      end
      OP_LUI: begin
        a_d = '0;
        b_d = imm;
      end
      default: begin
        a_d = '0;
        b_d = '0;
      end
    endcase
  end

`ifdef OPERANDS_OUTREG_EN
  logic [DWIDTH-1:0] a_q;
  logic [DWIDTH-1:0] b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign A = a_q;
  assign B = b_q;
`else
  // Clock and reset are only meaningful for the registered build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;

  assign A = a_d;
  assign B = b_d;
`endif

endmodule

// File: tb/tb_operands_select.sv
// Scoreboard bench for operands_select: stimulus pushes expected A/B, a negedge monitor checks.
// Honours OPERANDS_OUTREG_EN to match the registered build's latency and reset behaviour.
module tb_operands_select;

`ifdef OPERANDS_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd_mw;
  logic [31:0] pc, rs1d, rs2d, imm, wb_data_mw;
  logic        rwe_mw;
  logic [31:0] A, B;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          due;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  operands_select #(.DWIDTH(32), .RWIDTH(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rs1(rs1), .rs2(rs2),
    .pc(pc), .rs1d(rs1d), .rs2d(rs2d), .imm(imm), .rd_mw(rd_mw),
    .rwe_mw(rwe_mw), .wb_data_mw(wb_data_mw), .A(A), .B(B)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s vec%0d: got 0x%08h, required 0x%08h", name, id, act, req);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the capturing edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.due != cyc) check("due_cycle", e.id, 32'(cyc), 32'(e.due));
      check("A", e.id, A, e.a);
      check("B", e.id, B, e.b);
      $display("vec%0d op=%07b A=0x%08h B=0x%08h (exp 0x%08h 0x%08h)", e.id, opcode, A, B, e.a, e.b);
    end
  end

  task automatic drive(input int id, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] p, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] im, input logic [4:0] rd, input logic we,
                       input logic [31:0] wb, input logic [31:0] ea, input logic [31:0] eb,
                       input int lat);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op; rs1 = r1; rs2 = r2; pc = p; rs1d = d1; rs2d = d2;
    imm = im; rd_mw = rd; rwe_mw = we; wb_data_mw = wb;
    e.a = ea; e.b = eb; e.due = cyc + lat; e.id = id;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    opcode = '0; rs1 = '0; rs2 = '0; rd_mw = '0; rwe_mw = 1'b0;
    pc = '0; rs1d = '0; rs2d = '0; imm = '0; wb_data_mw = '0;

    // Reset state: registered build holds zero, combinational build ignores reset.
`ifdef OPERANDS_OUTREG_EN
    drive(0, OP_R, 5'd3, 5'd4, 32'h0, 32'h11, 32'h22, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
`else
    drive(0, OP_R, 5'd3, 5'd4, 32'h0, 32'h11, 32'h22, 32'h0, 5'd0, 1'b0, 32'h0, 32'h11, 32'h22, 0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;

    //     id op         rs1    rs2    pc            rs1d          rs2d          imm           rd     we    wb            expA          expB
    drive(1,  OP_R,      5'd3,  5'd4,  32'h0,        32'h11,       32'h22,       32'h0,        5'd0,  1'b0, 32'h0,        32'h11,       32'h22,       LAT);
    drive(2,  OP_R,      5'd3,  5'd4,  32'h0,        32'h11,       32'h22,       32'h0,        5'd3,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h22,       LAT);
    drive(3,  OP_I_ALU,  5'd0,  5'd1,  32'h0,        32'h0,        32'h9,        32'h7FF,      5'd0,  1'b1, 32'h55,       32'h0,        32'h7FF,      LAT);
    drive(4,  OP_AUIPC,  5'd1,  5'd2,  32'h2000,     32'h99,       32'h98,       32'h12345000, 5'd0,  1'b0, 32'h0,        32'h2000,     32'h12345000, LAT);
    drive(5,  OP_LUI,    5'd1,  5'd2,  32'h2000,     32'h99,       32'h98,       32'h12345000, 5'd1,  1'b1, 32'h77,       32'h0,        32'h12345000, LAT);
    drive(6,  OP_STORE,  5'd5,  5'd7,  32'h40,       32'hA5,       32'h3,        32'h8,        5'd7,  1'b1, 32'hCAFE,     32'hA5,       32'h8,        LAT);
    drive(7,  7'b0000000,5'd5,  5'd6,  32'h44,       32'h123,      32'h456,      32'h789,      5'd5,  1'b1, 32'hABC,      32'h0,        32'h0,        LAT);
    drive(8,  OP_R,      5'd9,  5'd9,  32'h0,        32'h1,        32'h2,        32'h0,        5'd9,  1'b1, 32'h12345678, 32'h12345678, 32'h12345678, LAT);
    drive(9,  OP_R,      5'd9,  5'd9,  32'h0,        32'h1,        32'h2,        32'h0,        5'd9,  1'b0, 32'h12345678, 32'h1,        32'h2,        LAT);
    drive(10, OP_R,      5'd1,  5'd2,  32'h0,        32'h10,       32'h20,       32'h0,        5'd2,  1'b1, 32'hBEEF,     32'h10,       32'hBEEF,     LAT);
    drive(11, OP_LOAD,   5'd6,  5'd7,  32'h0,        32'h1000,     32'h5,        32'hFFFFFFFC, 5'd7,  1'b1, 32'h66,       32'h1000,     32'hFFFFFFFC, LAT);
    drive(12, OP_JALR,   5'd8,  5'd3,  32'h50,       32'h1,        32'h2,        32'h4,        5'd8,  1'b1, 32'h400,      32'h400,      32'h4,        LAT);
    drive(13, OP_BRANCH, 5'd4,  5'd5,  32'h80,       32'h33,       32'h44,       32'hFFFFFFF0, 5'd4,  1'b1, 32'h99,       32'h80,       32'hFFFFFFF0, LAT);
    drive(14, OP_JAL,    5'd0,  5'd0,  32'h100,      32'h0,        32'h0,        32'h800,      5'd0,  1'b0, 32'h0,        32'h100,      32'h800,      LAT);
    drive(15, OP_CSR,    5'd2,  5'd0,  32'h0,        32'h77,       32'h0,        32'h300,      5'd3,  1'b1, 32'h5,        32'h77,       32'h300,      LAT);
    drive(16, 7'h7F,     5'd2,  5'd3,  32'h10,       32'h77,       32'h88,       32'h300,      5'd2,  1'b1, 32'h5,        32'h0,        32'h0,        LAT);
    drive(17, OP_R,      5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        5'd0,  1'b1, 32'hFFFF,     32'h0,        32'h0,        LAT);
    drive(18, OP_I_ALU,  5'd31, 5'd0,  32'h0,        32'h1,        32'h0,        32'hFFFFFFFF, 5'd31, 1'b1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, LAT);

    repeat (4) @(negedge clk);
    #1;
    check("queue_drained", 99, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations still pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

endmodule
